// File: rtl/vedic_mul_pkg.sv
// Shared types and sizing for the round-robin arbiter in front of a single vedic 8x8 multiplier.
package vedic_mul_pkg;

  localparam int unsigned NUM_REQ_DEF = 4;
  localparam int unsigned OP_W        = 8;
  localparam int unsigned PROD_W      = 16;

  // Tag width for n requesters, never narrower than one bit.
  function automatic int unsigned id_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/vedic_mul_arbiter_vedic_8X8.sv
// Combinational 8x8 unsigned multiplier built from vedic 2x2 -> 4x4 -> 8x8 crosswise blocks.
module vedic_8X8
  import vedic_mul_pkg::*;
(
  input  logic [OP_W-1:0]   i_a,
  input  logic [OP_W-1:0]   i_b,
  output logic [PROD_W-1:0] o_prod_c
);

  function automatic logic [3:0] v2(input logic [1:0] a, input logic [1:0] b);
    logic c1, c2, cy, t;
    c1 = a[1] & b[0];
    c2 = a[0] & b[1];
    cy = c1 & c2;
    t  = a[1] & b[1];
    return {t & cy, t ^ cy, c1 ^ c2, a[0] & b[0]};
  endfunction

  // Each level combines four half-width products: low, two cross terms, high.
  function automatic logic [7:0] v4(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] p0, p1, p2, p3;
    p0 = v2(a[1:0], b[1:0]);
    p1 = v2(a[3:2], b[1:0]);
    p2 = v2(a[1:0], b[3:2]);
    p3 = v2(a[3:2], b[3:2]);
    return 8'(p0) + 8'({p1, 2'b00}) + 8'({p2, 2'b00}) + {p3, 4'b0000};
  endfunction

  function automatic logic [15:0] v8(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p0, p1, p2, p3;
    p0 = v4(a[3:0], b[3:0]);
    p1 = v4(a[7:4], b[3:0]);
    p2 = v4(a[3:0], b[7:4]);
    p3 = v4(a[7:4], b[7:4]);
    return 16'(p0) + 16'({p1, 4'b0000}) + 16'({p2, 4'b0000}) + {p3, 8'b0000_0000};
  endfunction

  assign o_prod_c = v8(i_a, i_b);

endmodule

// File: rtl/vedic_mul_arbiter.sv
// Round-robin arbiter sharing one vedic 8x8 multiplier among NUM_REQ requesters.
// Fixed two-edge latency from transfer to res_valid; result held until consumed.
module vedic_mul_arbiter
  import vedic_mul_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_REQ_DEF,
  parameter int unsigned ID_W    = id_w(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0][OP_W-1:0]  req_a,
  input  logic [NUM_REQ-1:0][OP_W-1:0]  req_b,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          res_valid,
  output logic [PROD_W-1:0]             res_data,
  output logic [ID_W-1:0]               res_id,
  input  logic                          res_ready,
  output logic                          busy
);

  state_e              r_state;
  logic [ID_W-1:0]     r_ptr;
  logic [OP_W-1:0]     r_op_a;
  logic [OP_W-1:0]     r_op_b;
  logic [ID_W-1:0]     r_tag;
  logic                r_res_valid;
  logic [PROD_W-1:0]   r_res_data;
  logic [ID_W-1:0]     r_res_id;
  logic                r_busy;

  logic [NUM_REQ-1:0]  w_grant;
  logic [ID_W-1:0]     w_gnt_id;
  logic [ID_W-1:0]     w_idx;
  logic                w_found;
  logic                w_xfer;
  logic [ID_W-1:0]     w_ptr_nxt;
  logic [PROD_W-1:0]   w_prod;

  // Round-robin search starting at r_ptr, ascending with wrap; first valid wins.
  always_comb begin
    w_grant  = '0;
    w_gnt_id = '0;
    w_idx    = '0;
    w_found  = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_idx = ID_W'((32'(r_ptr) + k) % NUM_REQ);
      if (!w_found && req_valid[w_idx]) begin
        w_found         = 1'b1;
        w_grant[w_idx]  = 1'b1;
        w_gnt_id        = w_idx;
      end
    end
  end

  assign w_xfer    = (r_state == IDLE) && w_found;
  assign w_ptr_nxt = (w_gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt_id + ID_W'(1);

  // rst_n gating keeps req_ready quiet while reset is held with requests pending.
  assign req_ready = ((r_state == IDLE) && rst_n) ? w_grant : '0;

  vedic_8X8 u_mul (
    .i_a      (r_op_a),
    .i_b      (r_op_b),
    .o_prod_c (w_prod)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_tag       <= '0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_id    <= '0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_xfer) begin
            r_op_a  <= req_a[w_gnt_id];
            r_op_b  <= req_b[w_gnt_id];
            r_tag   <= w_gnt_id;
            r_ptr   <= w_ptr_nxt;
            r_state <= MUL;
            r_busy  <= 1'b1;
          end
        end
        MUL: begin
          r_res_data  <= w_prod;
          r_res_id    <= r_tag;
          r_res_valid <= 1'b1;
          r_state     <= HOLD;
        end
        HOLD: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_state     <= IDLE;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_res_valid <= 1'b0;
          r_state     <= IDLE;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign res_id    = r_res_id;
  assign busy      = r_busy;

endmodule

// File: doc/vedic_mul_arbiter.md
VEDIC_MUL_ARBITER -- requirements
Module: vedic_mul_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing one vedic_8X8 multiplier; legal range 2..8.
REQ-002 Parameter ID_W, default $clog2(NUM_REQ), width of the requester tag.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 req_valid  input  NUM_REQ  per-requester operand-valid.
REQ-006 req_a  input  NUM_REQ x 8  per-requester multiplicand, unsigned.
REQ-007 req_b  input  NUM_REQ x 8  per-requester multiplier, unsigned.
REQ-008 req_ready  output  NUM_REQ  per-requester accept, one-hot or zero.
REQ-009 res_valid  output  1  product available.
REQ-010 res_data  output  16  unsigned product req_a*req_b of the granted requester.
REQ-011 res_id  output  ID_W  index of the requester that owns res_data.
REQ-012 res_ready  input  1  consumer accepts the result.
REQ-013 busy  output  1  high whenever state is not IDLE.

Function
REQ-014 FSM states IDLE, MUL, HOLD; exactly one active.
REQ-015 IDLE: req_ready SHALL equal the round-robin grant vector (combinational from req_valid and pointer); zero when no req_valid set.
REQ-016 Round-robin: search starts at index ptr, ascending, wraps NUM_REQ-1 -> 0; first set req_valid wins.
REQ-017 Transfer = req_valid[i] & req_ready[i]; on transfer capture req_a[i], req_b[i], i into operand/tag registers, ptr <= (i+1) mod NUM_REQ, state -> MUL.
REQ-018 IDLE with no req_valid: stay IDLE, ptr unchanged.
REQ-019 MUL: register vedic_8X8 output from the operand registers into res_data, tag into res_id, set res_valid, state -> HOLD (one cycle, unconditional).
REQ-020 Latency: transfer at edge T -> res_valid high after edge T+2; fixed, data-independent.
REQ-021 HOLD: res_valid, res_data, res_id held stable until res_valid & res_ready; then res_valid <= 0, state -> IDLE.
REQ-022 req_ready SHALL be 0 in MUL and HOLD; maximum throughput one product per 3 cycles with res_ready held high.
REQ-023 res_ready low indefinitely: result held, no request accepted, no operand lost.
REQ-024 Requester dropping req_valid before transfer: no capture, no pointer change; no stickiness assumed.
REQ-025 Width: full 16-bit product, no truncation; 0xFF*0xFF = 0xFE01, any x*0 = 0x0000.
REQ-026 res_data/res_id SHALL NOT change while res_valid is high.

Reset
REQ-027 rst_n low: state IDLE, ptr 0, res_valid 0, res_data 0x0000, res_id 0, busy 0, req_ready 0 while reset asserted; operand registers 0.
REQ-028 Reset mid-operation (MUL or HOLD): in-flight product discarded, no res_valid after release until a new transfer.
REQ-029 First grant after reset release goes to the lowest-index valid requester.

Structure
REQ-030 Package vedic_mul_pkg holds NUM_REQ default, ID_W derivation, and the FSM state enum (IDLE, MUL, HOLD).
REQ-031 Exactly one existing vedic_8X8 instance as sub-module; no other multiplier logic in this block.
REQ-032 Arbitration, pointer and FSM in this module; no combinational path from res_ready to req_ready.

Verification
REQ-033 Single request: req_valid=0001, a=0x0F, b=0x11 -> req_ready=0001 one cycle, res_valid 2 edges later, res_data=0x00FF, res_id=0.
REQ-034 All valid continuously, res_ready=1 -> grant order 0,1,2,3,0 at one grant per 3 cycles; res_id matches order.
REQ-035 Corner products: 0xFF*0xFF -> 0xFE01; 0x80*0x02 -> 0x0100; 0x00*0xAB -> 0x0000.
REQ-036 Backpressure: res_ready=0 for 10 cycles in HOLD -> res_valid/res_data/res_id stable, req_ready=0, busy=1; res_ready=1 -> IDLE next edge.
REQ-037 Reset in HOLD: assert rst_n low with res_valid=1 -> outputs cleared asynchronously, no result after release, next grant to lowest valid index.
REQ-038 Withdrawn request: requester 2 pulses req_valid only during MUL -> never granted, ptr unchanged.
